gcd_requester: RTL and testbench

Hardware requester for the GCD unit's val/rdy interfaces: drives operand pairs into `operands_*` and consumes and checks `result_*`. It is the initiator counterpart to the GCD responder and replaces the behavioural source/sink pair when a synthesizable self-test is needed. It walks a fixed 8-entry vector ROM in order, keeps up to `MAX_OUT` requests in flight, compares each result against the expected value, and reports pass/fail, error count and timeout.

---
 rtl/gcd_requester.sv | 214 +++++++++++++++++++++
 tb/tb_gcd_requester.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_requester.sv
// Synthesizable requester for the GCD unit's val/rdy interfaces: it drives an 8-entry
// operand ROM into the responder, checks each in-order result, and reports pass/fail.
module gcd_requester #(
    parameter int unsigned W       = 32,
    parameter int unsigned NUM_VEC = 8,
    parameter int unsigned MAX_OUT = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    output logic [W-1:0] operands_bits_A,
    output logic [W-1:0] operands_bits_B,
    output logic         operands_val,
    input  logic         operands_rdy,
    input  logic [W-1:0] result_bits_data,
    input  logic         result_val,
    output logic         result_rdy,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [7:0]   err_count,
    output logic [2:0]   first_err_idx,
    output logic         timed_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0]  LAST_IDX = 4'(NUM_VEC - 1);
    localparam logic [3:0]  VEC_LIM  = 4'(NUM_VEC);
    localparam logic [2:0]  OUT_LIM  = 3'(MAX_OUT);
    localparam logic [16:0] WD_LIM   = 17'(TIMEOUT);

    function automatic logic [7:0] rom_a(input logic [2:0] idx);
        case (idx)
            3'd0:    rom_a = 8'd27;
            3'd1:    rom_a = 8'd21;
            3'd2:    rom_a = 8'd25;
            3'd3:    rom_a = 8'd19;
            3'd4:    rom_a = 8'd40;
            3'd5:    rom_a = 8'd250;
            3'd6:    rom_a = 8'd5;
            3'd7:    rom_a = 8'd0;
            default: rom_a = 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] rom_b(input logic [2:0] idx);
        case (idx)
            3'd0:    rom_b = 8'd15;
            3'd1:    rom_b = 8'd49;
            3'd2:    rom_b = 8'd30;
            3'd3:    rom_b = 8'd27;
            3'd4:    rom_b = 8'd40;
            3'd5:    rom_b = 8'd190;
            3'd6:    rom_b = 8'd250;
            3'd7:    rom_b = 8'd0;
            default: rom_b = 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] rom_e(input logic [2:0] idx);
        case (idx)
            3'd0:    rom_e = 8'd3;
            3'd1:    rom_e = 8'd7;
            3'd2:    rom_e = 8'd5;
            3'd3:    rom_e = 8'd1;
            3'd4:    rom_e = 8'd40;
            3'd5:    rom_e = 8'd10;
            3'd6:    rom_e = 8'd5;
            3'd7:    rom_e = 8'd0;
            default: rom_e = 8'd0;
        endcase
    endfunction

    logic [1:0]  state_q, state_d;
    logic [3:0]  iss_idx_q, iss_idx_d;
    logic [3:0]  chk_idx_q, chk_idx_d;
    logic [2:0]  outst_q, outst_d;
    logic [7:0]  err_q, err_d;
    logic [2:0]  first_q, first_d;
    logic        to_q, to_d;
    logic [15:0] wd_q, wd_d;

    logic         run;
    logic         op_fire;
    logic         res_fire;
    logic         mismatch;
    logic [W-1:0] exp_word;
    logic [16:0]  wd_inc;

    assign run          = (state_q == ST_RUN);
    assign operands_val = run && (iss_idx_q < VEC_LIM) && (outst_q < OUT_LIM);
    assign result_rdy   = run && (outst_q != 3'd0);
    assign op_fire      = operands_val && operands_rdy;
    assign res_fire     = result_val && result_rdy;
    assign exp_word     = {{(W-8){1'b0}}, rom_e(chk_idx_q[2:0])};
    assign mismatch     = (result_bits_data != exp_word);
    assign wd_inc       = {1'b0, wd_q} + 17'd1;

    // Operand bits are forced to zero outside RUN so idle outputs read as all-zero.
    assign operands_bits_A = run ? {{(W-8){1'b0}}, rom_a(iss_idx_q[2:0])} : {W{1'b0}};
    assign operands_bits_B = run ? {{(W-8){1'b0}}, rom_b(iss_idx_q[2:0])} : {W{1'b0}};

    assign busy          = run;
    assign done          = (state_q == ST_DONE);
    assign pass          = done && (err_q == 8'd0) && !to_q;
    assign err_count     = err_q;
    assign first_err_idx = first_q;
    assign timed_out     = to_q;

    // Next-state logic: run control, issue/check bookkeeping and watchdog.
    always_comb begin
        state_d   = state_q;
        iss_idx_d = iss_idx_q;
        chk_idx_d = chk_idx_q;
        outst_d   = outst_q;
        err_d     = err_q;
        first_d   = first_q;
        to_d      = to_q;
        wd_d      = wd_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    iss_idx_d = 4'd0;
                    chk_idx_d = 4'd0;
                    outst_d   = 3'd0;
                    err_d     = 8'd0;
                    first_d   = 3'd0;
                    to_d      = 1'b0;
                    wd_d      = 16'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (op_fire) begin
                    iss_idx_d = iss_idx_q + 4'd1;
                end else begin
                    iss_idx_d = iss_idx_q;
                end
                if (op_fire && !res_fire) begin
                    outst_d = outst_q + 3'd1;
                end else if (!op_fire && res_fire) begin
                    outst_d = outst_q - 3'd1;
                end else begin
                    outst_d = outst_q;
                end
                // A result fire always resets the watchdog, so expiry and completion never collide.
                if (res_fire) begin
                    chk_idx_d = chk_idx_q + 4'd1;
                    wd_d      = 16'd0;
                    if (mismatch) begin
                        if (err_q != 8'hFF) begin
                            err_d = err_q + 8'd1;
                        end else begin
                            err_d = err_q;
                        end
                        if (err_q == 8'd0) begin
                            first_d = chk_idx_q[2:0];
                        end else begin
                            first_d = first_q;
                        end
                    end else begin
                        err_d = err_q;
                    end
                    if (chk_idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (outst_q == 3'd0) begin
                    wd_d = 16'd0;
                end else if (wd_inc >= WD_LIM) begin
                    wd_d    = wd_inc[15:0];
                    to_d    = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wd_d = wd_inc[15:0];
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            iss_idx_q <= 4'd0;
            chk_idx_q <= 4'd0;
            outst_q   <= 3'd0;
            err_q     <= 8'd0;
            first_q   <= 3'd0;
            to_q      <= 1'b0;
            wd_q      <= 16'd0;
        end else begin
            state_q   <= state_d;
            iss_idx_q <= iss_idx_d;
            chk_idx_q <= chk_idx_d;
            outst_q   <= outst_d;
            err_q     <= err_d;
            first_q   <= first_d;
            to_q      <= to_d;
            wd_q      <= wd_d;
        end
    end

endmodule

// File: tb/tb_gcd_requester.sv
// Directed bench for gcd_requester: instance 0 (MAX_OUT=2, TIMEOUT=16) and instance 1
// (MAX_OUT=1) are each driven by an in-order GCD responder model running on the falling edge.
module tb_gcd_requester;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    typedef struct {
        logic       corrupt;
        logic       alt;
        logic [7:0] exp_err;
        logic [2:0] exp_first;
        logic       exp_pass;
        int         exp_ticks;
    } scen_t;

    logic        clk;
    logic        reset_n;
    logic        start [2];
    logic [31:0] opa   [2];
    logic [31:0] opb   [2];
    logic        opv   [2];
    logic        opr   [2];
    logic [31:0] rd    [2];
    logic        rv    [2];
    logic        rr    [2];
    logic        busy  [2];
    logic        done  [2];
    logic        pass  [2];
    logic [7:0]  errc  [2];
    logic [2:0]  fidx  [2];
    logic        tmo   [2];

    // responder model state
    logic        rdy_en  [2];
    logic        rsp_en  [2];
    logic        rsp_alt [2];
    logic        corrupt [2];
    logic [31:0] qd [2][8];
    int          qh [2];
    int          qc [2];
    int          nop [2];
    int          nres [2];
    int          outst [2];
    int          maxo [2];
    int          both [2];
    int          last_res [2];
    int          tick_n;
    int          run_ticks;
    int          n_cmp;
    int          n_bad;

    vec_t  vec [8];
    scen_t sc  [4];

    gcd_requester #(.W(32), .NUM_VEC(8), .MAX_OUT(2), .TIMEOUT(16)) u0 (
        .clk(clk), .reset_n(reset_n), .start(start[0]),
        .operands_bits_A(opa[0]), .operands_bits_B(opb[0]),
        .operands_val(opv[0]), .operands_rdy(opr[0]),
        .result_bits_data(rd[0]), .result_val(rv[0]), .result_rdy(rr[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(errc[0]), .first_err_idx(fidx[0]), .timed_out(tmo[0])
    );

    gcd_requester #(.W(32), .NUM_VEC(8), .MAX_OUT(1), .TIMEOUT(1024)) u1 (
        .clk(clk), .reset_n(reset_n), .start(start[1]),
        .operands_bits_A(opa[1]), .operands_bits_B(opb[1]),
        .operands_val(opv[1]), .operands_rdy(opr[1]),
        .result_bits_data(rd[1]), .result_val(rv[1]), .result_rdy(rr[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(errc[1]), .first_err_idx(fidx[1]), .timed_out(tmo[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] gcd(input logic [31:0] a_in, input logic [31:0] b_in);
        logic [31:0] a, b, t;
        a = a_in;
        b = b_in;
        while (b != 32'd0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic model_clear(input int i);
        qh[i] = 0; qc[i] = 0; nop[i] = 0; nres[i] = 0;
        outst[i] = 0; maxo[i] = 0; both[i] = 0; last_res[i] = -10;
    endtask

    // Called just after a falling edge: set responder inputs, then predict the fires of the next rising edge.
    task automatic resp_step();
        for (int i = 0; i < 2; i++) begin
            logic        op_f, rs_f;
            logic [31:0] v;
            opr[i] = rdy_en[i];
            rv[i]  = rsp_en[i] && (qc[i] > 0) && !(rsp_alt[i] && tick_n[0]);
            rd[i]  = (qc[i] > 0) ? qd[i][qh[i]] : 32'd0;
            op_f = opv[i] && opr[i];
            rs_f = rv[i] && rr[i];
            if (opv[i] === 1'b1 && rr[i] === 1'b1) both[i]++;
            if (rs_f === 1'b1) begin
                qh[i] = (qh[i] + 1) % 8;
                qc[i]--;
                nres[i]++;
                outst[i]--;
                last_res[i] = tick_n;
            end
            if (op_f === 1'b1) begin
                if (nop[i] < 8) begin
                    chk($sformatf("opA[%0d]", nop[i]), opa[i], vec[nop[i]].a);
                    chk($sformatf("opB[%0d]", nop[i]), opb[i], vec[nop[i]].b);
                    v = gcd(opa[i], opb[i]);
                    if (corrupt[i] && nop[i] == 2) v = 32'd6;
                    if (corrupt[i] && nop[i] == 5) v = 32'd11;
                    qd[i][(qh[i] + qc[i]) % 8] = v;
                    qc[i]++;
                end
                nop[i]++;
                outst[i]++;
                if (outst[i] > maxo[i]) maxo[i] = outst[i];
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        tick_n++;
        resp_step();
    endtask

    task automatic start_run(input int i);
        model_clear(i);
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
        chk("busy_after_start", {31'd0, busy[i]}, 32'd1);
        chk("val_after_start", {31'd0, opv[i]}, 32'd1);
    endtask

    task automatic run_to_done(input int i, input int budget);
        int c;
        c = 0;
        while (c < budget && done[i] !== 1'b1) begin
            tick();
            c++;
        end
        run_ticks = c;
        chk("done_reached", {31'd0, done[i]}, 32'd1);
        chk("done_one_after_last_fire", tick_n, last_res[i] + 1);
        chk("op_fires", nop[i], 8);
        chk("res_fires", nres[i], 8);
        chk("busy_low_in_done", {31'd0, busy[i]}, 32'd0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; tick_n = 0; run_ticks = 0;
        vec[0] = '{32'd27, 32'd15};  vec[1] = '{32'd21, 32'd49};
        vec[2] = '{32'd25, 32'd30};  vec[3] = '{32'd19, 32'd27};
        vec[4] = '{32'd40, 32'd40};  vec[5] = '{32'd250, 32'd190};
        vec[6] = '{32'd5, 32'd250};  vec[7] = '{32'd0, 32'd0};
        //           corrupt alt  err    first  pass  ticks
        sc[0] = '{1'b0, 1'b0, 8'd0, 3'd0, 1'b1, 9};
        sc[1] = '{1'b1, 1'b0, 8'd2, 3'd2, 1'b0, 9};
        sc[2] = '{1'b0, 1'b1, 8'd0, 3'd0, 1'b1, 0};
        sc[3] = '{1'b1, 1'b1, 8'd2, 3'd2, 1'b0, 0};
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; rdy_en[i] = 1'b1; rsp_en[i] = 1'b1;
            rsp_alt[i] = 1'b0; corrupt[i] = 1'b0;
            opr[i] = 1'b0; rv[i] = 1'b0; rd[i] = 32'd0;
            model_clear(i);
        end
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            chk("rst_val", {31'd0, opv[i]}, 32'd0);
            chk("rst_rdy", {31'd0, rr[i]}, 32'd0);
            chk("rst_busy", {31'd0, busy[i]}, 32'd0);
            chk("rst_done", {31'd0, done[i]}, 32'd0);
            chk("rst_pass", {31'd0, pass[i]}, 32'd0);
            chk("rst_err", {24'd0, errc[i]}, 32'd0);
            chk("rst_first", {29'd0, fidx[i]}, 32'd0);
            chk("rst_tmo", {31'd0, tmo[i]}, 32'd0);
            chk("rst_A", opa[i], 32'd0);
            chk("rst_B", opb[i], 32'd0);
        end

        // table-driven full runs on instance 0
        for (int s = 0; s < 4; s++) begin
            corrupt[0] = sc[s].corrupt;
            rsp_alt[0] = sc[s].alt;
            start_run(0);
            run_to_done(0, 200);
            if (sc[s].exp_ticks != 0) chk("run_length", run_ticks, sc[s].exp_ticks);
            chk("pass", {31'd0, pass[0]}, {31'd0, sc[s].exp_pass});
            chk("err_count", {24'd0, errc[0]}, {24'd0, sc[s].exp_err});
            chk("first_err_idx", {29'd0, fidx[0]}, {29'd0, sc[s].exp_first});
            chk("timed_out", {31'd0, tmo[0]}, 32'd0);
            chk("maxout_le_2", {31'd0, (maxo[0] <= 2)}, 32'd1);
            repeat (3) tick();
            chk("hold_done", {31'd0, done[0]}, 32'd1);
            chk("hold_err", {24'd0, errc[0]}, {24'd0, sc[s].exp_err});
            chk("hold_val", {31'd0, opv[0]}, 32'd0);
            chk("hold_rdy", {31'd0, rr[0]}, 32'd0);
        end
        corrupt[0] = 1'b0;
        rsp_alt[0] = 1'b0;

        // operands_rdy low for 5 cycles with vector 2 pending
        start_run(0);
        for (int c = 0; c < 20 && nop[0] < 2; c++) tick();
        rdy_en[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("stall_val", {31'd0, opv[0]}, 32'd1);
            chk("stall_A", opa[0], 32'd25);
            chk("stall_B", opb[0], 32'd30);
            chk("stall_no_fire", nop[0], 2);
        end
        rdy_en[0] = 1'b1;
        run_to_done(0, 200);
        chk("stall_pass", {31'd0, pass[0]}, 32'd1);

        // watchdog: results never returned
        rsp_en[0] = 1'b0;
        start_run(0);
        run_ticks = 0;
        for (int c = 1; c <= 40 && run_ticks == 0; c++) begin
            tick();
            if (done[0] === 1'b1) run_ticks = c;
        end
        chk("timeout_cycle", run_ticks, 17);
        chk("timeout_flag", {31'd0, tmo[0]}, 32'd1);
        chk("timeout_pass", {31'd0, pass[0]}, 32'd0);
        chk("timeout_busy", {31'd0, busy[0]}, 32'd0);
        chk("timeout_rdy", {31'd0, rr[0]}, 32'd0);
        rsp_en[0] = 1'b1;

        // reset mid-run at vector 4, then a clean rerun
        start_run(0);
        for (int c = 0; c < 20 && nop[0] < 4; c++) tick();
        reset_n = 1'b0;
        tick();
        model_clear(0);
        reset_n = 1'b1;
        chk("mid_rst_val", {31'd0, opv[0]}, 32'd0);
        chk("mid_rst_rdy", {31'd0, rr[0]}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy[0]}, 32'd0);
        chk("mid_rst_err", {24'd0, errc[0]}, 32'd0);
        chk("mid_rst_A", opa[0], 32'd0);
        tick();
        start_run(0);
        chk("rerun_A0", opa[0], 32'd27);
        run_to_done(0, 200);
        chk("rerun_pass", {31'd0, pass[0]}, 32'd1);

        // MAX_OUT=1: one request in flight, issue and check alternate
        start_run(1);
        run_to_done(1, 200);
        chk("m1_run_length", run_ticks, 16);
        chk("m1_maxout", maxo[1], 1);
        chk("m1_no_overlap", both[1], 0);
        chk("m1_pass", {31'd0, pass[1]}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
